// File: rtl/cpu_gen2.sv
`timescale 1ns/1ps
// cpu_gen2: LED-matrix CPU with a register file, carry flag and 2-byte instructions
// fetched over a req/ack handshake. It scans the register file onto the matrix pins.
// Instruction layout: {imm[7:0], op[4:0], sss[2:0]}.
module cpu_gen2 #(
    parameter int DW      = 8,
    parameter int NREG    = 8,
    parameter int PCW     = 11,
    parameter int SCAN_SH = 13
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    output logic            imem_req,
    output logic [PCW-1:0]  imem_addr,
    input  logic            imem_ack,
    input  logic [15:0]     imem_data,
    output logic [DW-1:0]   row,
    output logic [NREG-1:0] col,
    output logic [3:0]      led,
    output logic            halted
);

    localparam int RW = $clog2(NREG);
    localparam int SW = SCAN_SH + RW;

    localparam logic [4:0] OP_ADD  = 5'b01000;
    localparam logic [4:0] OP_OR   = 5'b01001;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_XOR  = 5'b01011;
    localparam logic [4:0] OP_INC  = 5'b01100;
    localparam logic [4:0] OP_NOT  = 5'b01101;
    localparam logic [4:0] OP_RROT = 5'b01110;
    localparam logic [4:0] OP_LROT = 5'b01111;
    localparam logic [4:0] OP_JNC  = 5'b10000;
    localparam logic [4:0] OP_JC   = 5'b10001;
    localparam logic [4:0] OP_JMP  = 5'b10010;
    localparam logic [4:0] OP_MVI  = 5'b10100;
    localparam logic [4:0] OP_SUB  = 5'b10101;
    localparam logic [4:0] OP_HLT  = 5'b11111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t          r_state;
    logic [PCW-1:0]  r_pc;
    logic            r_c;
    logic [15:0]     r_ir;
    logic [DW-1:0]   r_regs [NREG];
    logic [SW-1:0]   r_scan;

    // Instruction fields
    logic [4:0]      w_op;
    logic [2:0]      w_sss;
    logic [7:0]      w_imm;
    logic [RW-1:0]   w_ri;
    logic [RW-1:0]   w_di;
    logic [DW-1:0]   w_rv;
    logic [DW-1:0]   w_r0;
    logic [DW:0]     w_add;
    logic [DW:0]     w_sub;
    logic [DW:0]     w_inc;
    logic [PCW-1:0]  w_pc_inc;
    logic [PCW-1:0]  w_target;

    // Execute results
    logic            w_wr_en;
    logic [RW-1:0]   w_wr_idx;
    logic [DW-1:0]   w_wr_data;
    logic            w_c_nxt;
    logic [PCW-1:0]  w_pc_nxt;
    logic            w_hlt;

    // Scan view
    logic [RW-1:0]   w_scan_col;
    logic [DW-1:0]   w_col_val;

    assign w_op     = r_ir[7:3];
    assign w_sss    = r_ir[2:0];
    assign w_imm    = r_ir[15:8];
    assign w_ri     = w_sss[RW-1:0];
    assign w_di     = w_op[RW-1:0];
    assign w_rv     = r_regs[w_ri];
    assign w_r0     = r_regs[0];
    assign w_add    = {1'b0, w_r0} + {1'b0, w_rv};
    assign w_sub    = {1'b0, w_r0} - {1'b0, w_rv};
    assign w_inc    = {1'b0, w_rv} + (DW+1)'(1);
    assign w_pc_inc = r_pc + PCW'(2);
    assign w_target = PCW'({w_imm, 1'b0});

    // Decode the held instruction into register, flag and pc updates for EXEC.
    // NOTE: every output is given a default first, so no decode path can infer a latch.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_idx  = w_ri;
        w_wr_data = w_rv;
        w_c_nxt   = r_c;
        w_pc_nxt  = w_pc_inc;
        w_hlt     = 1'b0;
        casez (w_op)
            5'b00???: begin
                w_wr_en   = 1'b1;
                w_wr_idx  = w_di;
                w_wr_data = w_rv;
            end
            OP_ADD: begin
                w_wr_en   = 1'b1;
                w_wr_idx  = '0;
                w_wr_data = w_add[DW-1:0];
                w_c_nxt   = w_add[DW];
            end
            OP_OR: begin
                w_wr_en   = 1'b1;
                w_wr_idx  = '0;
                w_wr_data = w_r0 | w_rv;
            end
            OP_AND: begin
                w_wr_en   = 1'b1;
                w_wr_idx  = '0;
                w_wr_data = w_r0 & w_rv;
            end
            OP_XOR: begin
                w_wr_en   = 1'b1;
                w_wr_idx  = '0;
                w_wr_data = w_r0 ^ w_rv;
            end
            OP_INC: begin
                w_wr_en   = 1'b1;
                w_wr_data = w_inc[DW-1:0];
                w_c_nxt   = w_inc[DW];
            end
            OP_NOT: begin
                w_wr_en   = 1'b1;
                w_wr_data = ~w_rv;
            end
            OP_RROT: begin
                w_wr_en   = 1'b1;
                w_wr_data = {w_rv[0], w_rv[DW-1:1]};
            end
            OP_LROT: begin
                w_wr_en   = 1'b1;
                w_wr_data = {w_rv[DW-2:0], w_rv[DW-1]};
            end
            OP_JNC: begin
                w_pc_nxt = r_c ? w_pc_inc : w_target;
                w_c_nxt  = 1'b0;
            end
            OP_JC: begin
                w_pc_nxt = r_c ? w_target : w_pc_inc;
                w_c_nxt  = 1'b0;
            end
            OP_JMP: begin
                w_pc_nxt = w_target;
            end
            OP_MVI: begin
                w_wr_en   = 1'b1;
                w_wr_data = DW'(w_imm);
            end
            OP_SUB: begin
                w_wr_en   = 1'b1;
                w_wr_idx  = '0;
                w_wr_data = w_sub[DW-1:0];
                w_c_nxt   = w_sub[DW];
            end
            OP_HLT: begin
                w_pc_nxt = r_pc;
                w_hlt    = 1'b1;
            end
            default: ;
        endcase
    end

    // Control FSM: fetch handshake, execute commit of pc/flag, run gating and halt.
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_c     <= 1'b0;
            r_ir    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (run) r_state <= S_FETCH;
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        r_ir    <= imem_data;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    r_pc <= w_pc_nxt;
                    r_c  <= w_c_nxt;
                    if (w_hlt)    r_state <= S_HALT;
                    else if (run) r_state <= S_FETCH;
                    else          r_state <= S_IDLE;
                end
                S_HALT: r_state <= S_HALT;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Register file write port, active only in EXEC.
    // NOTE: the register file is built from flops and must read zero after reset, so it is cleared.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else if (r_state == S_EXEC && w_wr_en) begin
            r_regs[w_wr_idx] <= w_wr_data;
        end
    end

    // Free-running scan counter, which also keeps running while halted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_scan <= '0;
        else     r_scan <= r_scan + SW'(1);
    end

    assign w_scan_col = r_scan[SW-1:SCAN_SH];
    assign w_col_val  = r_regs[w_scan_col];
    assign col        = ~(NREG'(1) << w_scan_col);

    // Row drive is the scanned register with its bits reversed.
    always_comb begin
        row = '0;
        for (int j = 0; j < DW; j++) row[j] = w_col_val[DW-1-j];
    end

    assign imem_req  = (r_state == S_FETCH);
    assign imem_addr = r_pc;
    assign halted    = (r_state == S_HALT);
    assign led       = {halted, r_c, (r_state == S_EXEC), run};

endmodule

// File: tb/tb_cpu_gen2.sv
`timescale 1ns/1ps
// Directed bench for cpu_gen2. The main instance has a short scan, and a small
// PCW=4/NREG=4 instance covers pc wrap and the scan wrap.
module tb_cpu_gen2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        run4 = 1'b0;
    logic        ack_force = 1'b0;
    logic        ack_en = 1'b0;
    int          wait_n = 0;
    int          wcnt;
    int          n_tests = 0;
    int          n_fail = 0;

    logic        imem_req, imem_ack, halted;
    logic [10:0] imem_addr;
    logic [15:0] imem_data;
    logic [7:0]  row, col;
    logic [3:0]  led;
    logic [15:0] mem [0:1023];

    logic        req4, halted4;
    logic [3:0]  addr4, col4, led4;
    logic [15:0] data4;
    logic [7:0]  row4;
    logic [15:0] mem4 [0:7];

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr[10:1]];
    assign data4     = mem4[addr4[3:1]];
    assign imem_ack  = ack_force || (ack_en && imem_req && (wcnt >= wait_n));

    // Counts the wait cycles of the current fetch request.
    always @(posedge clk or posedge rst) begin
        if (rst)                       wcnt <= 0;
        else if (!imem_req || imem_ack) wcnt <= 0;
        else                           wcnt <= wcnt + 1;
    end

    cpu_gen2 #(.DW(8), .NREG(8), .PCW(11), .SCAN_SH(2)) u_dut (
        .clk(clk), .rst(rst), .run(run),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .row(row), .col(col), .led(led), .halted(halted)
    );

    cpu_gen2 #(.DW(8), .NREG(4), .PCW(4), .SCAN_SH(2)) u_dut4 (
        .clk(clk), .rst(rst), .run(run4),
        .imem_req(req4), .imem_addr(addr4), .imem_ack(1'b1), .imem_data(data4),
        .row(row4), .col(col4), .led(led4), .halted(halted4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Reset released on a negedge; tick(n) then lands on the negedge after the n-th posedge.
    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        for (int i = 0; i < 8; i++) mem4[i] = 16'h0000;
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    // Waits for column k of the main instance, then checks the register shown on row.
    task automatic chk_reg(input string tag, input int k, input logic [7:0] exp);
        logic [7:0] want;
        int n;
        want = ~(8'h01 << k);
        n = 0;
        while (col !== want && n < 64) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_col"}, col, want);
        check(tag, rev8(row), exp);
    endtask

    task automatic wait_halt(input string tag, input int budget);
        int n;
        n = 0;
        while (halted !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, halted, 1'b1);
    endtask

    initial begin
        int n_req;
        int saw5;

        // Program {MVI r0,F0; MVI r1,20; ADD r1; JC 08} with ack tied high.
        clear_mem();
        mem[0] = 16'hF0A0; mem[1] = 16'h20A1; mem[2] = 16'h0041; mem[3] = 16'h0888;
        mem[8] = 16'h00F8;
        ack_force = 1'b1; ack_en = 1'b0; run = 1'b1;
        do_reset();
        tick(1);
        check("t2_req_first", imem_req, 1'b1);
        check("t2_addr_first", imem_addr, 11'h000);
        tick(1);
        check("t2_exec_pulse", led[1], 1'b1);
        tick(5);
        check("t2_carry_set", led[2], 1'b1);
        check("t2_pc_after_add", imem_addr, 11'h006);
        tick(2);
        check("t2_carry_clr", led[2], 1'b0);
        check("t2_pc_jc", imem_addr, 11'h010);
        wait_halt("t2_halt", 20);
        chk_reg("t2_r0", 0, 8'h10);
        chk_reg("t2_r1", 1, 8'h20);

        // Same program with three wait cycles per fetch.
        ack_force = 1'b0; ack_en = 1'b1; wait_n = 3;
        do_reset();
        tick(1);
        check("t3_req_w0", imem_req, 1'b1);
        check("t3_addr_w0", imem_addr, 11'h000);
        tick(3);
        check("t3_req_w3", imem_req, 1'b1);
        check("t3_addr_w3", imem_addr, 11'h000);
        check("t3_ack_w3", imem_ack, 1'b1);
        tick(1);
        check("t3_exec_pulse", led[1], 1'b1);
        tick(11);
        check("t3_carry_set", led[2], 1'b1);
        check("t3_pc_after_add", imem_addr, 11'h006);
        tick(5);
        check("t3_carry_clr", led[2], 1'b0);
        check("t3_pc_jc", imem_addr, 11'h010);
        wait_halt("t3_halt", 40);
        chk_reg("t3_r0", 0, 8'h10);
        chk_reg("t3_r1", 1, 8'h20);

        // Reset mid-fetch drops the request at once and clears state.
        ack_en = 1'b0;
        do_reset();
        tick(3);
        check("t1_req_fetch", imem_req, 1'b1);
        rst = 1'b1;
        ack_force = 1'b1;
        #1;
        check("t1_req_drop", imem_req, 1'b0);
        check("t1_halted", halted, 1'b0);
        check("t1_addr", imem_addr, 11'h000);
        check("t1_col", col, 8'hFE);
        check("t1_row", row, 8'h00);
        @(negedge clk);
        rst = 1'b0; ack_force = 1'b0; run = 1'b0;
        tick(1);
        check("t1_no_exec", led[1], 1'b0);
        check("t1_no_req", imem_req, 1'b0);
        check("t1_carry", led[2], 1'b0);
        for (int k = 0; k < 8; k++) chk_reg($sformatf("t1_r%0d", k), k, 8'h00);

        // Boundaries: INC FF, JNC clears carry, SUB 00-01.
        clear_mem();
        mem[0] = 16'hFFA2; mem[1] = 16'h0062; mem[2] = 16'h00A0; mem[3] = 16'h01A3;
        mem[4] = 16'h0080; mem[5] = 16'h00AB; mem[6] = 16'h00F8;
        ack_force = 1'b1; run = 1'b1;
        do_reset();
        tick(5);
        check("t4_inc_carry", led[2], 1'b1);
        tick(6);
        check("t4_jnc_clr", led[2], 1'b0);
        check("t4_jnc_pc", imem_addr, 11'h00A);
        tick(2);
        check("t4_sub_borrow", led[2], 1'b1);
        wait_halt("t4_halt", 20);
        check("t4_hlt_pc", imem_addr, 11'h00C);
        chk_reg("t4_r0_sub", 0, 8'hFF);
        chk_reg("t4_r2_inc", 2, 8'h00);
        chk_reg("t4_r3", 3, 8'h01);

        // Run gating and halt behaviour.
        clear_mem();
        mem[0] = 16'h11A1; mem[1] = 16'h22A2; mem[2] = 16'h00F8;
        do_reset();
        tick(2);
        check("t5_exec", led[1], 1'b1);
        run = 1'b0;
        tick(1);
        check("t5_idle_req", imem_req, 1'b0);
        check("t5_idle_pc", imem_addr, 11'h002);
        check("t5_led_run", led[0], 1'b0);
        tick(4);
        check("t5_idle_req_hold", imem_req, 1'b0);
        run = 1'b1;
        tick(1);
        check("t5_resume_req", imem_req, 1'b1);
        check("t5_resume_pc", imem_addr, 11'h002);
        wait_halt("t5_halt", 20);
        check("t5_led_halt", led[3], 1'b1);
        check("t5_hlt_pc", imem_addr, 11'h004);
        n_req = 0; saw5 = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (imem_req) n_req++;
            if (col == 8'hDF) saw5++;
        end
        check("t5_halt_no_req", n_req, 0);
        check("t5_halt_scan", (saw5 > 0), 1'b1);
        chk_reg("t5_r1", 1, 8'h11);
        chk_reg("t5_r2", 2, 8'h22);

        // Logic, rotate, MOV, JMP, ADD with r=0 and NOP.
        clear_mem();
        mem[0] = 16'h5AA0; mem[1] = 16'h0FA1; mem[2] = 16'h0020; mem[3] = 16'h0059;
        mem[4] = 16'h0049; mem[5] = 16'h0051; mem[6] = 16'h006C; mem[7] = 16'h0071;
        mem[8] = 16'h007C; mem[9] = 16'h1090; mem[10] = 16'hEEA5;
        mem[16] = 16'h0031; mem[17] = 16'h0040; mem[18] = 16'h0098; mem[19] = 16'h00F8;
        do_reset();
        wait_halt("t7_halt", 80);
        check("t7_hlt_pc", imem_addr, 11'h026);
        check("t7_carry", led[2], 1'b0);
        chk_reg("t7_r0", 0, 8'h1E);
        chk_reg("t7_r1", 1, 8'h87);
        chk_reg("t7_r4", 4, 8'h4B);
        chk_reg("t7_r5_skipped", 5, 8'h00);
        chk_reg("t7_r6", 6, 8'h87);

        // Scan timing on both instances; small instance also checks pc wrap.
        clear_mem();
        mem[0] = 16'h81A3; mem[1] = 16'h00F8;
        mem4[0] = 16'h1790; mem4[7] = 16'h33A1;
        run4 = 1'b1;
        do_reset();
        for (int n = 1; n <= 16; n++) begin
            tick(1);
            if (n == 3) begin
                check("t6_jmp_trunc", addr4, 4'hE);
                run4 = 1'b0;
            end
            if (n == 5) begin
                check("t6_pc_wrap", addr4, 4'h0);
                check("t6_idle4", req4, 1'b0);
                check("t6_col4_c1", col4, 4'hD);
                check("t6_row4_r1", row4, 8'hCC);
            end
            if (n == 11) check("t6_col_c2", col, 8'hFB);
            if (n >= 12 && n <= 15) begin
                check($sformatf("t6_col_c3_%0d", n), col, 8'hF7);
                check($sformatf("t6_row_c3_%0d", n), row, 8'h81);
            end
            if (n == 15) check("t6_col4_c3", col4, 4'h7);
            if (n == 16) begin
                check("t6_col_c4", col, 8'hEF);
                check("t6_col4_wrap", col4, 4'hE);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before 500000 ns");
        $fatal(1);
    end

endmodule
